bit_serial_adder: RTL

//  Parametrised digit-serial two-operand adder/subtractor. It is the sequential successor of our
//  1-bit full adder tile: it reuses one DIGIT-wide adder slice over WIDTH/DIGIT cycles.
//  It sits behind the tt_um_* top wrapper and is fed from ui_in/uio_in via a start/ready handshake.

---
 rtl/bit_serial_adder_pkg.sv | 22 ++
 rtl/bit_serial_adder_if.sv | 26 ++
 rtl/bit_serial_adder_slice.sv | 28 ++
 rtl/bit_serial_adder.sv | 138 +++++++++++++
 4 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder family: FSM state encoding and
// step/counter sizing helpers.
package bit_serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int steps_f(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-step configuration still needs a 1-bit counter to keep the port legal.
  function automatic int cnt_w_f(input int width, input int digit);
    int steps;
    steps = width / digit;
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/bit_serial_adder_if.sv
// Start/ready request and result bus between the wrapper (master) and the
// digit-serial adder (slave).
interface bit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start_i;
  logic             sub_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             ready_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             ovf_o;

  modport master (
    output start_i, sub_i, a_i, b_i,
    input  ready_o, busy_o, done_o, sum_o, carry_o, ovf_o
  );

  modport slave (
    input  start_i, sub_i, a_i, b_i,
    output ready_o, busy_o, done_o, sum_o, carry_o, ovf_o
  );
endinterface

// File: rtl/bit_serial_adder_slice.sv
// Combinational DIGIT-bit ripple of full-adder cells; also exposes the carry
// into its MSB so the top level can derive two's-complement overflow.
module add_digit_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic c;

  always_comb begin
    sum      = '0;
    c        = cin;
    c_msb_in = cin;
    for (int i = 0; i < DIGIT; i++) begin
      c_msb_in = c;
      sum[i]   = a[i] ^ b[i] ^ c;
      c        = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/bit_serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT-wide slice reused over WIDTH/DIGIT
// cycles, LSB digit first, with a start/ready handshake and a one-cycle done pulse.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic              clk,
  input logic              rst,
  bit_serial_adder_if.slave bus
);

  localparam int STEPS = steps_f(WIDTH, DIGIT);
  localparam int CNT_W = cnt_w_f(WIDTH, DIGIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("bit_serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_out_q;
  logic             ovf_q;

  logic [DIGIT-1:0] sum_dig;
  logic             cout;
  logic             c_msb_in;

  logic             ready;
  logic             busy;
  logic             done;
  logic             accept;
  logic             last_step;

  add_digit_slice #(
    .DIGIT(DIGIT)
  ) u_slice (
    .a        (a_sr[DIGIT-1:0]),
    .b        (b_sr[DIGIT-1:0]),
    .cin      (carry_q),
    .sum      (sum_dig),
    .cout     (cout),
    .c_msb_in (c_msb_in)
  );

  // New digits enter at the MSB end so the LSB digit lands at bit 0 after STEPS shifts.
  if (STEPS > 1) begin : g_multi_step
    assign res_nxt = {sum_dig, res_sr[WIDTH-1:DIGIT]};
  end else begin : g_single_step
    assign res_nxt = sum_dig;
  end

  assign accept    = (state == S_IDLE) && bus.start_i;
  assign last_step = (state == S_RUN) && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (bus.start_i) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Subtraction is a + ~b + 1: invert B once at accept and seed the carry with 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      a_sr        <= '0;
      b_sr        <= '0;
      res_sr      <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      a_sr    <= bus.a_i;
      b_sr    <= bus.sub_i ? ~bus.b_i : bus.b_i;
      carry_q <= bus.sub_i;
    end else if (state == S_RUN) begin
      cnt     <= cnt + CNT_W'(1);
      a_sr    <= a_sr >> DIGIT;
      b_sr    <= b_sr >> DIGIT;
      res_sr  <= res_nxt;
      carry_q <= cout;
      if (last_step) begin
        sum_q       <= res_nxt;
        carry_out_q <= cout;
        ovf_q       <= c_msb_in ^ cout;
      end
    end
  end

  assign bus.ready_o = ready;
  assign bus.busy_o  = busy;
  assign bus.done_o  = done;
  assign bus.sum_o   = sum_q;
  assign bus.carry_o = carry_out_q;
  assign bus.ovf_o   = ovf_q;

endmodule
